serial_accumulator: RTL and testbench

SERIAL_ACCUMULATOR -- requirements
Module: serial_accumulator

---
 rtl/serial_accumulator.sv | 122 ++++++++++++
 tb/tb_serial_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_accumulator.sv
// Bit-serial accumulator: one full-adder slice and a carry flop process the
// operand LSB first, one bit per clock, then the result is committed to acc.
module serial_accumulator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] operand,
  input  logic             clear,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic             r_cout;

  logic             w_sum;
  logic             w_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_a_next;

  // Single full-adder slice on the current LSBs plus the registered carry.
  always_comb begin
    w_sum    = r_a[0] ^ r_b[0] ^ r_carry;
    w_carry  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_last   = (r_cnt == LastBit);
    w_a_next = {w_sum, r_a[WIDTH-1:1]};
  end

  // Next-state decode and status outputs; busy/done derive from state only.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!clear && start) w_state_next = StShift;
      end
      StShift: begin
        busy = 1'b1;
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Datapath: load on start, shift in SHIFT, commit results on the MSB slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (clear) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cout <= 1'b0;
          end else if (start) begin
            r_a     <= r_acc;
            // Subtract as acc + ~operand + 1: the +1 enters as the initial carry.
            r_b     <= sub ? ~operand : operand;
            r_carry <= sub;
            r_cnt   <= '0;
          end
        end
        StShift: begin
          r_a     <= w_a_next;
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CntW'(1);
          // Commit on the MSB slice so acc/ovf/cout are valid in the cycle done
          // is high. r_carry here is the carry into the MSB.
          if (w_last) begin
            r_acc  <= w_a_next;
            r_cout <= w_carry;
            r_ovf  <= r_carry ^ w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign acc  = r_acc;
  assign ovf  = r_ovf;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_accumulator.sv
// Scoreboard bench for serial_accumulator (WIDTH=8).
module tb_serial_accumulator;

  localparam int unsigned W = 8;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         start   = 1'b0;
  logic         sub     = 1'b0;
  logic         clear   = 1'b0;
  logic [W-1:0] operand = '0;
  logic [W-1:0] acc;
  logic         busy;
  logic         done;
  logic         ovf;
  logic         cout;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W+1:0] exp_q[$];   // {acc, ovf, cout}
  logic [W-1:0] m_acc = '0;

  always #5 clk = ~clk;

  serial_accumulator #(.WIDTH(W)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .operand (operand),
    .clear   (clear),
    .acc     (acc),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .cout    (cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic using integer math, independent of the bit-serial form.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic s,
                                         input logic [W-1:0] b);
    int           r;
    logic [W:0]   u;
    logic [W-1:0] res;
    logic         c;
    logic         o;
    if (s) begin
      r   = int'($signed(a)) - int'($signed(b));
      res = a - b;
      c   = (a >= b);
    end else begin
      r   = int'($signed(a)) + int'($signed(b));
      u   = {1'b0, a} + {1'b0, b};
      res = u[W-1:0];
      c   = u[W];
    end
    o = (r > 127) || (r < -128);
    return {res, o, c};
  endfunction

  // Pop and compare whenever the DUT signals a completed operation.
  always @(negedge clk) begin : mon
    logic [W+1:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("acc", 32'(acc), 32'(e[W+1:2]));
        check("ovf", 32'(ovf), 32'(e[1]));
        check("cout", 32'(cout), 32'(e[0]));
      end
    end
  end

  // Drive one operation starting in the current cycle; wait (bounded) for done.
  task automatic op(input logic s, input logic [W-1:0] b, input bit inject);
    logic [W+1:0] e;
    int           cyc;
    int           bcnt;
    bit           got;
    check("idle_before_start", 32'(busy), 32'd0);
    start   = 1'b1;
    sub     = s;
    operand = b;
    clear   = 1'b0;
    e       = model(m_acc, s, b);
    exp_q.push_back(e);
    m_acc   = e[W+1:2];
    @(posedge clk);
    #1;
    start   = 1'b0;
    sub     = ~s;
    operand = W'($urandom);
    cyc  = 0;
    bcnt = 0;
    got  = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
      // Disturb start/clear/operand mid-operation; all must be ignored.
      if (inject && cyc == 3) begin
        start   = 1'b1;
        clear   = 1'b1;
        sub     = 1'b1;
        operand = 8'h55;
      end
      if (inject && cyc == 4) begin
        start = 1'b0;
        clear = 1'b0;
      end
    end
    check("done_latency", 32'(cyc), 32'd9);
    check("busy_cycles", 32'(bcnt), 32'd9);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_acc = '0;
    check("clear_acc", 32'(acc), 32'd0);
    check("clear_ovf", 32'(ovf), 32'd0);
    check("clear_cout", 32'(cout), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int ndone;
    #1 rst_n = 1'b0;
    #1;
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    #10 rst_n = 1'b1;   // released between edges; first start taken at next edge

    op(1'b0, 8'd5, 1'b0);

    do_clear();
    op(1'b0, 8'd100, 1'b0);
    op(1'b0, 8'd50, 1'b0);
    op(1'b0, 8'h6A, 1'b0);

    do_clear();
    op(1'b0, 8'd5, 1'b0);
    op(1'b1, 8'd7, 1'b0);
    do_clear();
    op(1'b0, 8'h80, 1'b0);
    op(1'b1, 8'd1, 1'b0);

    op(1'b0, 8'd3, 1'b1);

    // clear wins over start in the same IDLE cycle
    clear   = 1'b1;
    start   = 1'b1;
    operand = 8'd9;
    @(posedge clk);
    #1;
    clear = 1'b0;
    start = 1'b0;
    m_acc = '0;
    @(negedge clk);
    check("clr_start_busy", 32'(busy), 32'd0);
    check("clr_start_acc", 32'(acc), 32'd0);
    @(negedge clk);
    check("clr_start_busy2", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      op(1'($urandom_range(0, 1)), W'($urandom), 1'b0);
    end

    // Asynchronous reset in the middle of SHIFT
    do_clear();
    op(1'b0, 8'h44, 1'b0);
    start   = 1'b1;
    sub     = 1'b0;
    operand = 8'h33;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_acc", 32'(acc), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    #3 rst_n = 1'b1;
    m_acc = '0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_rst", 32'(ndone), 32'd0);
    check("acc_after_rst", 32'(acc), 32'd0);
    @(posedge clk);
    #1;
    op(1'b0, 8'h21, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
